// File: rtl/spike_pkg.sv
// Shared types and limits for the spike arbiter: FSM state encoding,
// parameter bounds and the event-id width helper.
package spike_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OFFER,
    REFRACT
  } state_t;

  localparam int MAX_NEURONS = 16;
  localparam int MAX_REFRACT = 15;

  // Width of an index into n requesters; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first set request at or
// above ptr, wrapping modulo N, plus a flag that any request is set.
module rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] grant,
  output logic            any
);

  logic found;
  int   idx;

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        grant = ID_W'(idx);
        found = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/spike_arbiter.sv
// Spike event arbiter: latches one-cycle spikes, offers them round-robin
// over a valid/ready handshake with a refractory gap after each grant.
// Define SPIKE_ARB_DROP_CNT_EN to add the saturating drop_cnt output.
module spike_arbiter
  import spike_pkg::*;
#(
  parameter  int N_NEURONS      = 4,
  parameter  int REFRACT_CYCLES = 2,
  localparam int ID_W           = id_w(N_NEURONS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [N_NEURONS-1:0] spike_in,
  output logic                 ev_valid,
  output logic [ID_W-1:0]      ev_id,
  input  logic                 ev_ready,
  output logic [N_NEURONS-1:0] pending,
  output logic                 overflow,
`ifdef SPIKE_ARB_DROP_CNT_EN
  output logic [7:0]           drop_cnt,
`endif
  input  logic                 clr_ovf
);

  localparam logic [3:0] REF_LOAD = (REFRACT_CYCLES > 0) ? 4'(REFRACT_CYCLES - 1) : 4'd0;
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_NEURONS - 1);

  state_t                 state;
  logic [ID_W-1:0]        rr_ptr;
  logic [3:0]             ref_cnt;
  logic [ID_W-1:0]        pick_id;
  logic                   pick_any;
  logic                   handshake;
  logic                   can_offer;
  logic [N_NEURONS-1:0]   clr_mask;
  logic [N_NEURONS-1:0]   drops;

  rr_pick #(
    .N    (N_NEURONS),
    .ID_W (ID_W)
  ) u_pick (
    .req   (pending),
    .ptr   (rr_ptr),
    .grant (pick_id),
    .any   (pick_any)
  );

  assign handshake = (state == OFFER) && ev_ready;
  assign can_offer = ena && pick_any;

  // A spike arriving on the neuron being served this edge is a fresh spike, not a drop.
  always_comb begin
    clr_mask = '0;
    if (handshake) clr_mask[ev_id] = 1'b1;
    drops = spike_in & pending & ~clr_mask;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      pending <= (pending & ~clr_mask) | spike_in;
      if (|drops)       overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ev_valid <= 1'b0;
      ev_id    <= '0;
      rr_ptr   <= '0;
      ref_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (can_offer) begin
            ev_id    <= pick_id;
            ev_valid <= 1'b1;
            state    <= OFFER;
          end
        end
        OFFER: begin
          if (ev_ready) begin
            ev_valid <= 1'b0;
            rr_ptr   <= (ev_id == LAST_ID) ? '0 : ev_id + ID_W'(1);
            if (REFRACT_CYCLES == 0) begin
              state <= IDLE;
            end else begin
              state   <= REFRACT;
              ref_cnt <= REF_LOAD;
            end
          end
        end
        REFRACT: begin
          // The final dead cycle hands straight to the next offer, as IDLE would.
          if (ref_cnt != 4'd0) begin
            ref_cnt <= ref_cnt - 4'd1;
          end else if (can_offer) begin
            ev_id    <= pick_id;
            ev_valid <= 1'b1;
            state    <= OFFER;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPIKE_ARB_DROP_CNT_EN
  logic [4:0] n_drop;
  logic [8:0] drop_sum;

  always_comb begin
    n_drop = '0;
    for (int i = 0; i < N_NEURONS; i++) n_drop = n_drop + 5'(drops[i]);
    drop_sum = (clr_ovf ? 9'd0 : {1'b0, drop_cnt}) + 9'(n_drop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt <= '0;
    else        drop_cnt <= (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
  end
`endif

endmodule

// File: doc/spike_arbiter.md
SPIKE_ARBITER -- requirements
Module: spike_arbiter

Interface
REQ-001 Parameter N_NEURONS, default 4, SHALL set the number of spike requesters (range 2..16).
REQ-002 Parameter REFRACT_CYCLES, default 2, SHALL set the dead time after each grant (range 0..15).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 ena  input  1  arbiter enable; high permits new offers.
REQ-006 spike_in  input  N_NEURONS  one-cycle spike pulses, one bit per neuron.
REQ-007 ev_valid  output  1  a spike event is offered on ev_id.
REQ-008 ev_id  output  ID_W  index of the offered neuron; ID_W = clog2(N_NEURONS).
REQ-009 ev_ready  input  1  the downstream synapse accepts the event.
REQ-010 pending  output  N_NEURONS  per-neuron latched-but-unserved spike flags.
REQ-011 overflow  output  1  sticky flag: at least one spike was dropped.
REQ-012 clr_ovf  input  1  synchronous clear of overflow (and of drop_cnt when present).

Function
REQ-013 A spike_in[i] high at a clock edge SHALL set pending[i] at that edge, independent of ena and FSM state.
REQ-014 spike_in[i] high while pending[i] is already set and not being cleared that edge SHALL drop the spike and set overflow.
REQ-015 FSM states SHALL be IDLE, OFFER and REFRACT.
REQ-016 IDLE: when ena=1 and pending!=0, the next edge SHALL load ev_id with the first set bit at or above rr_ptr, wrapping modulo N_NEURONS, set ev_valid=1 and enter OFFER.
REQ-017 Latency: a spike sampled at edge E0 into an idle, empty, enabled arbiter SHALL have ev_valid=1 after edge E1.
REQ-018 OFFER: ev_valid and ev_id SHALL hold stable until an edge with ev_ready=1; ena low SHALL NOT withdraw an offer.
REQ-019 Handshake edge: pending[ev_id] SHALL clear, rr_ptr SHALL become (ev_id+1) mod N_NEURONS, ev_valid SHALL drop, and the FSM SHALL enter REFRACT, or IDLE if REFRACT_CYCLES=0.
REQ-020 A spike on neuron ev_id in the handshake cycle SHALL re-set pending (set wins over clear), without overflow.
REQ-021 REFRACT SHALL last exactly REFRACT_CYCLES cycles with ev_valid=0, then return to IDLE.
REQ-022 clr_ovf and a simultaneous new drop SHALL leave overflow=1 (set wins).
REQ-023 With ena=0 in IDLE, the FSM SHALL remain in IDLE while pending continues to accumulate.

Reset
REQ-024 rst_n low SHALL immediately force: FSM=IDLE, ev_valid=0, ev_id=0, pending=0, rr_ptr=0, refractory counter=0, overflow=0, drop_cnt=0.
REQ-025 Reset asserted mid-OFFER SHALL discard the offered event and all pending spikes; no event is replayed after release.

Configuration
REQ-026 Macro SPIKE_ARB_DROP_CNT_EN defined: output drop_cnt (8 bits) SHALL count dropped spikes, saturate at 255, and clear on clr_ovf.
REQ-027 Macro SPIKE_ARB_DROP_CNT_EN undefined: the drop_cnt port and counter SHALL be absent; all other behaviour is unchanged.

Structure
REQ-028 Package spike_pkg SHALL hold the FSM state enum (IDLE/OFFER/REFRACT), the maximum N_NEURONS and REFRACT_CYCLES limits, and the ID_W helper function.
REQ-029 The round-robin selection SHALL live in a combinational sub-module rr_pick (inputs: request vector and pointer; outputs: grant index and any flag).

Verification
REQ-030 N=4, REFRACT=2: reset, ena=1, pulse spike_in=0001 -> ev_valid=1, ev_id=0 two edges later; ev_ready=1 -> ev_valid=0 for 2 cycles, pending=0.
REQ-031 spike_in=1111 in one cycle, ev_ready held at 1 -> grants in order 0,1,2,3, each 3 cycles apart; overflow=0.
REQ-032 rr_ptr=2 with pending=0011 -> next ev_id=0, then 1 (wrap check).
REQ-033 Hold ev_ready=0 for 5 cycles -> ev_id is stable; a second spike on the offered neuron sets overflow and, with the macro defined, drop_cnt=1; clr_ovf -> both read 0.
REQ-034 Spike on neuron 3 on the handshake edge of ev_id=3 -> pending[3]=1 afterwards, overflow=0.
REQ-035 Assert rst_n=0 mid-OFFER with pending=0110 -> all outputs read 0 immediately, before the next clk edge.
